depacketizer: RTL
=================

DEPACKETIZER -- requirements
Module: depacketizer

Interface
REQ-001 SHALL have parameter SYNC_MAX_ERR, default 2, maximum symbol mismatches tolerated in the sync window when DEPACKETIZER_SYNC_TOL_EN is defined.
REQ-002 SHALL have port clk  input  1  symbol clock (1.024MHz domain).
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port MODE_CTRL  input  4  mode select; 4'b0001 BPSK, 4'b0010 QPSK, 4'b0100 MIX.
REQ-005 SHALL have ports in_tdata  input  2  hard-decision symbol (bit0 carries BPSK/header bit); in_tvalid  input  1; in_tready  output  1.
REQ-006 SHALL have ports out_tdata  output  2; out_tvalid  output  1; out_tlast  output  1; out_tuser  output  1  (is_bpsk).
REQ-007 SHALL have status ports hdr_vld  output  1  (1-cycle pulse); payload_length  output  16  (decoded bits); hdr_err  output  1  (pulse); pkt_recv  output  1  (pulse).

Function
REQ-008 SHALL count only beats with in_tvalid=1; in_tready SHALL be 1 whenever not in reset (no backpressure on the demodulator).
REQ-009 SHALL, when MODE_CTRL != MIX, register in_tdata/in_tvalid to out_tdata/out_tvalid with 1-cycle latency, out_tuser = (MODE_CTRL==BPSK), out_tlast=0, status outputs 0, FSM held in HUNT.
REQ-010 SHALL, in MIX, implement FSM states HUNT, MODE, LEN, PAD, PLD.
REQ-011 HUNT: SHALL shift bit0 into a 48-symbol window and leave HUNT when the window equals SYNC_PATTERN (oldest first: 16 symbols 0,1,0,1..., then 32 symbols 1,0,1,0...,0).
REQ-012 MODE: SHALL collect 8 symbols and compare with 1,0,1,0,1,0,1,0; >=6 agreements -> BPSK, <=2 -> QPSK, otherwise pulse hdr_err and return to HUNT.
REQ-013 LEN: SHALL collect 16 bit0 values MSB first into payload_length and pulse hdr_vld on the cycle after the 16th symbol.
REQ-014 SHALL compute payload_symbs = BPSK ? payload_length : payload_length>>1 (QPSK odd lengths floor); payload_symbs==0 SHALL pulse hdr_err and return to HUNT.
REQ-015 PAD: SHALL discard exactly 40 symbols without inspecting them.
REQ-016 PLD: SHALL forward each valid beat to out_tdata with out_tvalid=1 one cycle later, out_tuser = decoded is_bpsk; out_tvalid=0 for invalid input beats.
REQ-017 SHALL assert out_tlast with the payload_symbs-th payload beat, pulse pkt_recv one cycle later, and return to HUNT with the sync window cleared.
REQ-018 SHALL keep out_tvalid=0 in all states except PLD (MIX) and pass-through mode.
REQ-019 SHALL return to HUNT and clear counters when MODE_CTRL changes mid-packet; no out_tlast SHALL be emitted for the aborted packet.
REQ-020 SHALL use a 16-bit payload counter; payload_symbs=65535 SHALL complete without wrap.

Reset
REQ-021 SHALL, with rst=1 at a clk edge, set state=HUNT, window and counters 0, in_tready=0, out_tdata=0, out_tvalid=0, out_tlast=0, out_tuser=1, hdr_vld=0, hdr_err=0, pkt_recv=0, payload_length=0.
REQ-022 SHALL abort any packet in progress on reset; first valid output after reset requires a new full sync.

Configuration
REQ-023 SHALL, with DEPACKETIZER_SYNC_TOL_EN defined, declare sync when Hamming distance(window, SYNC_PATTERN) <= SYNC_MAX_ERR; without it, exact match only and SYNC_MAX_ERR is unused.

Structure
REQ-024 SHALL take MODE_* codes, SYNC_PATTERN, field lengths (8/16/40) and state encodings from shared package depacketizer_pkg.
REQ-025 SHALL place window shifting and match/popcount logic in sub-module sync_correlator (output: match pulse).

Verification
REQ-026 MIX, BPSK header length=5, payload 1,0,1,1,0 -> hdr_vld, payload_length=5, 5 out beats with out_tuser=1, tlast on 5th, pkt_recv pulse.
REQ-027 MIX, QPSK header length=6 -> 3 payload beats, out_tuser=0, tlast on 3rd.
REQ-028 Mode field 1,1,0,0,1,1,0,0 (4 agreements) -> hdr_err pulse, no out_tvalid, re-sync on next packet succeeds.
REQ-029 Two sync-window symbol errors: with DEPACKETIZER_SYNC_TOL_EN packet received; without it, no hdr_vld.
REQ-030 in_tvalid gaps of 3 cycles inside payload -> out_tvalid gaps match, beat count and tlast unchanged.
REQ-031 rst asserted at payload beat 2 of 5 -> outputs at reset values next cycle, no tlast, next packet decoded correctly.

Source files
------------

// File: rtl/depacketizer_pkg.sv
// Shared constants, state encoding and helpers for the depacketizer.
// Header layout: 48-symbol sync, 8-symbol mode field, 16-bit length, 40 pad symbols, payload.
package depacketizer_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    localparam int unsigned SYNC_LEN = 48;

    // Oldest symbol sits in the MSB: 16 symbols 0101..., then 32 symbols 1010...0
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 48'h5555_AAAA_AAAA;

    localparam logic [15:0] MODE_SYMS = 16'd8;
    localparam logic [15:0] LEN_SYMS  = 16'd16;
    localparam logic [15:0] PAD_SYMS  = 16'd40;
    localparam logic [15:0] MODE_LAST = MODE_SYMS - 16'd1;
    localparam logic [15:0] LEN_LAST  = LEN_SYMS - 16'd1;
    localparam logic [15:0] PAD_LAST  = PAD_SYMS - 16'd1;

    // Mode reference 1,0,1,0,1,0,1,0 with the first symbol in the MSB
    localparam logic [7:0] MODE_REF = 8'b1010_1010;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_MODE,
        ST_LEN,
        ST_PAD,
        ST_PLD
    } state_t;

    function automatic int unsigned popcount48(input logic [SYNC_LEN-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < SYNC_LEN; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_correlator.sv
// 48-symbol sliding sync window with a combinational match pulse on the completing beat.
// DEPACKETIZER_SYNC_TOL_EN: accept up to SYNC_MAX_ERR mismatching symbols instead of an exact match.
module sync_correlator
    import depacketizer_pkg::*;
#(
    parameter int unsigned SYNC_MAX_ERR = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match
);

    logic [SYNC_LEN-1:0] r_window;
    logic [SYNC_LEN-1:0] w_next;
    logic                w_hit;

    assign w_next = {r_window[SYNC_LEN-2:0], i_bit};

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_window <= '0;
        end else if (i_shift) begin
            r_window <= w_next;
        end
    end

`ifdef DEPACKETIZER_SYNC_TOL_EN
    assign w_hit = (popcount48(w_next ^ SYNC_PATTERN) <= SYNC_MAX_ERR);
`else
    logic [31:0] w_unused_max_err;
    assign w_unused_max_err = SYNC_MAX_ERR;
    assign w_hit = (w_next == SYNC_PATTERN);
`endif

    // Match is judged on the window including the incoming symbol
    assign o_match = i_shift && w_hit;

endmodule

// File: rtl/depacketizer.sv
// Symbol-stream depacketizer: pass-through in BPSK/QPSK, header-decoding FSM in MIX mode.
// Optional DEPACKETIZER_SYNC_TOL_EN enables tolerant sync detection in sync_correlator.
module depacketizer
    import depacketizer_pkg::*;
#(
    parameter int unsigned SYNC_MAX_ERR = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  MODE_CTRL,
    input  logic [1:0]  in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [1:0]  out_tdata,
    output logic        out_tvalid,
    output logic        out_tlast,
    output logic        out_tuser,
    output logic        hdr_vld,
    output logic [15:0] payload_length,
    output logic        hdr_err,
    output logic        pkt_recv
);

    state_t      r_state, w_state_nxt;
    logic        w_mix, w_match, w_corr_clear, w_corr_shift;
    logic [15:0] r_cnt, r_symbs, r_payload_length;
    logic [15:0] w_len_word, w_len_symbs;
    logic [14:0] r_shift;
    logic        r_is_bpsk;
    int unsigned w_mode_diff;
    logic        w_set_mode, w_mode_bpsk, w_len_done, w_hdr_ok, w_hdr_err, w_pld_last;
    logic [1:0]  r_out_tdata;
    logic        r_out_tvalid, r_out_tlast, r_out_tuser;
    logic        r_hdr_vld, r_hdr_err, r_pkt_recv;

    assign w_mix        = (MODE_CTRL == MODE_MIX);
    assign w_corr_shift = w_mix && (r_state == ST_HUNT) && in_tvalid;
    assign w_corr_clear = !w_mix || (r_state != ST_HUNT);
    assign w_len_word   = {r_shift, in_tdata[0]};
    assign w_len_symbs  = r_is_bpsk ? w_len_word : {1'b0, w_len_word[15:1]};
    assign w_mode_diff  = popcount48({40'd0, r_shift[6:0], in_tdata[0]} ^ {40'd0, MODE_REF});

    sync_correlator #(
        .SYNC_MAX_ERR(SYNC_MAX_ERR)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_corr_clear),
        .i_shift (w_corr_shift),
        .i_bit   (in_tdata[0]),
        .o_match (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_HUNT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_mode  = 1'b0;
        w_mode_bpsk = 1'b0;
        w_len_done  = 1'b0;
        w_hdr_ok    = 1'b0;
        w_hdr_err   = 1'b0;
        w_pld_last  = 1'b0;
        if (!w_mix) begin
            w_state_nxt = ST_HUNT;
        end else begin
            case (r_state)
                ST_HUNT: if (w_match) w_state_nxt = ST_MODE;
                ST_MODE: if (in_tvalid && r_cnt == MODE_LAST) begin
                    // >=6 agreements means <=2 differing symbols, and vice versa
                    if (w_mode_diff <= 32'd2) begin
                        w_state_nxt = ST_LEN;
                        w_set_mode  = 1'b1;
                        w_mode_bpsk = 1'b1;
                    end else if (w_mode_diff >= 32'd6) begin
                        w_state_nxt = ST_LEN;
                        w_set_mode  = 1'b1;
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_hdr_err   = 1'b1;
                    end
                end
                ST_LEN: if (in_tvalid && r_cnt == LEN_LAST) begin
                    w_len_done = 1'b1;
                    if (w_len_symbs == '0) begin
                        w_state_nxt = ST_HUNT;
                        w_hdr_err   = 1'b1;
                    end else begin
                        w_state_nxt = ST_PAD;
                        w_hdr_ok    = 1'b1;
                    end
                end
                ST_PAD: if (in_tvalid && r_cnt == PAD_LAST) w_state_nxt = ST_PLD;
                ST_PLD: if (in_tvalid && r_cnt == r_symbs - 16'd1) begin
                    w_state_nxt = ST_HUNT;
                    w_pld_last  = 1'b1;
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt            <= '0;
            r_shift          <= '0;
            r_symbs          <= '0;
            r_is_bpsk        <= 1'b0;
            r_payload_length <= '0;
            r_out_tdata      <= '0;
            r_out_tvalid     <= 1'b0;
            r_out_tlast      <= 1'b0;
            r_out_tuser      <= 1'b1;
            r_hdr_vld        <= 1'b0;
            r_hdr_err        <= 1'b0;
            r_pkt_recv       <= 1'b0;
        end else if (!w_mix) begin
            r_cnt            <= '0;
            r_shift          <= '0;
            r_payload_length <= '0;
            r_out_tdata      <= in_tdata;
            r_out_tvalid     <= in_tvalid;
            r_out_tlast      <= 1'b0;
            r_out_tuser      <= (MODE_CTRL == MODE_BPSK);
            r_hdr_vld        <= 1'b0;
            r_hdr_err        <= 1'b0;
            r_pkt_recv       <= 1'b0;
        end else begin
            r_hdr_vld    <= w_hdr_ok;
            r_hdr_err    <= w_hdr_err;
            r_pkt_recv   <= r_out_tlast;
            r_out_tvalid <= 1'b0;
            r_out_tlast  <= 1'b0;
            // Counter restarts on every state change; payload run ends at r_symbs-1, so no wrap
            if (w_state_nxt != r_state)                r_cnt <= '0;
            else if (in_tvalid && r_state != ST_HUNT)  r_cnt <= r_cnt + 16'd1;
            if (in_tvalid)  r_shift          <= w_len_word[14:0];
            if (w_set_mode) r_is_bpsk        <= w_mode_bpsk;
            if (w_len_done) r_payload_length <= w_len_word;
            if (w_hdr_ok)   r_symbs          <= w_len_symbs;
            if (r_state == ST_PLD && in_tvalid) begin
                r_out_tdata  <= in_tdata;
                r_out_tvalid <= 1'b1;
                r_out_tuser  <= r_is_bpsk;
                r_out_tlast  <= w_pld_last;
            end
        end
    end

    assign in_tready      = ~rst;
    assign out_tdata      = r_out_tdata;
    assign out_tvalid     = r_out_tvalid;
    assign out_tlast      = r_out_tlast;
    assign out_tuser      = r_out_tuser;
    assign hdr_vld        = r_hdr_vld;
    assign payload_length = r_payload_length;
    assign hdr_err        = r_hdr_err;
    assign pkt_recv       = r_pkt_recv;

endmodule
